// File: rtl/gray_threshold_stream_if.sv
// AXI4-Stream bundle for the gray threshold stage: handshake, data, byte qualifiers and sideband.
interface gray_threshold_stream_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]     tkeep;
    logic [KEEP_W-1:0]     tstrb;
    logic                  tuser;
    logic                  tlast;
    logic                  tid;
    logic                  tdest;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tuser, tlast, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tuser, tlast, tid, tdest,
        output tready
    );
endinterface

// File: rtl/gray_threshold_stream.sv
// Binarises a gray AXI4-Stream against a per-frame threshold, checks frame geometry, counts frames.
// Optional GRAY_THRESH_STATS_EN adds white_count (white pixels of the last completed frame).
module gray_threshold_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIM_W      = 12,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [7:0]              threshold,
    input  logic                    invert,
    input  logic [DIM_W-1:0]        cfg_cols,
    input  logic [DIM_W-1:0]        cfg_rows,
    input  logic                    clear_err,
    gray_threshold_stream_if.slave  input_stream,
    gray_threshold_stream_if.master output_stream,
    output logic                    frame_done,
    output logic [FCNT_W-1:0]       frame_count,
    output logic                    err_eol_early,
    output logic                    err_eol_late,
    output logic                    err_sof_early
`ifdef GRAY_THRESH_STATS_EN
    ,
    output logic [2*DIM_W-1:0]      white_count
`endif
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned BEAT_W = DATA_WIDTH + 2 * KEEP_W + 4;

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   col_q, col_d, row_q, row_d, col_eff, row_eff, last_col, last_row;
    logic [7:0]         thr_q, thr_d, thr_eff;
    logic               inv_q, inv_d, inv_eff;
    logic               done_d, set_early, set_late, set_sof;
    logic [FCNT_W-1:0]  fcnt_d;

    logic               in_ready_q, out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [BEAT_W-1:0]  out_beat_q, out_beat_d, skid_beat_q, skid_beat_d, beat_in;

    logic               accept, sof, eol, geo_en, frame_beat, pix_white;
    logic               unused_tdata_hi;

    assign accept     = input_stream.tvalid && in_ready_q;
    assign sof        = input_stream.tuser;
    assign eol        = input_stream.tlast;
    assign geo_en     = (cfg_cols != '0) && (cfg_rows != '0);
    assign last_col   = cfg_cols - DIM_W'(1);
    assign last_row   = cfg_rows - DIM_W'(1);
    assign frame_beat = (state_q == ACTIVE) || sof;

    // An SOF beat is already binarised with the values it captures.
    assign thr_eff         = sof ? threshold : thr_q;
    assign inv_eff         = sof ? invert : inv_q;
    assign pix_white       = (input_stream.tdata[7:0] >= thr_eff) ^ inv_eff;
    assign unused_tdata_hi = ^input_stream.tdata[DATA_WIDTH-1:8];

    assign beat_in = {{DATA_WIDTH{pix_white}}, input_stream.tkeep, input_stream.tstrb,
                      input_stream.tuser, input_stream.tlast, input_stream.tid, input_stream.tdest};

    assign input_stream.tready  = in_ready_q;
    assign output_stream.tvalid = out_valid_q;
    assign {output_stream.tdata, output_stream.tkeep, output_stream.tstrb, output_stream.tuser,
            output_stream.tlast, output_stream.tid, output_stream.tdest} = out_beat_q;

    // Output register plus one skid entry; input is accepted only while the skid is empty.
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_beat_d   = out_beat_q;
        skid_beat_d  = skid_beat_q;
        if (accept) begin
            if (!out_valid_q || output_stream.tready) begin
                out_beat_d  = beat_in;
                out_valid_d = 1'b1;
            end else begin
                skid_beat_d  = beat_in;
                skid_valid_d = 1'b1;
            end
        end else if (out_valid_q && output_stream.tready) begin
            if (skid_valid_q) begin
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Frame tracking: an SOF beat is treated as col 0 / row 0 regardless of the counters.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        thr_d     = thr_q;
        inv_d     = inv_q;
        done_d    = 1'b0;
        fcnt_d    = frame_count;
        set_early = 1'b0;
        set_late  = 1'b0;
        set_sof   = 1'b0;
        col_eff   = sof ? '0 : col_q;
        row_eff   = sof ? '0 : row_q;
        if (accept && sof) begin
            thr_d   = threshold;
            inv_d   = invert;
            state_d = ACTIVE;
            set_sof = geo_en && (state_q == ACTIVE) && ((col_q != '0) || (row_q != '0));
        end
        if (accept && frame_beat) begin
            if (eol) begin
                col_d     = '0;
                row_d     = row_eff + DIM_W'(1);
                set_early = geo_en && (col_eff < last_col);
                if (geo_en && (row_eff == last_row)) begin
                    done_d  = 1'b1;
                    fcnt_d  = frame_count + FCNT_W'(1);
                    row_d   = '0;
                    state_d = WAIT_SOF;
                end
            end else if (col_eff >= last_col) begin
                col_d    = col_eff;
                set_late = geo_en;
            end else begin
                col_d = col_eff + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= WAIT_SOF;
            col_q         <= '0;
            row_q         <= '0;
            thr_q         <= '0;
            inv_q         <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            out_beat_q    <= '0;
            skid_beat_q   <= '0;
            frame_done    <= 1'b0;
            frame_count   <= '0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
            err_sof_early <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            thr_q         <= thr_d;
            inv_q         <= inv_d;
            in_ready_q    <= !skid_valid_d;
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            out_beat_q    <= out_beat_d;
            skid_beat_q   <= skid_beat_d;
            frame_done    <= done_d;
            frame_count   <= fcnt_d;
            err_eol_early <= (err_eol_early && !clear_err) || set_early;
            err_eol_late  <= (err_eol_late && !clear_err) || set_late;
            err_sof_early <= (err_sof_early && !clear_err) || set_sof;
        end
    end

`ifdef GRAY_THRESH_STATS_EN
    localparam int unsigned CNT_W = 2 * DIM_W;

    logic [CNT_W-1:0] wcnt_q, wcnt_d, white_d;

    // Running white count; restarts on every SOF, published when the frame completes.
    always_comb begin
        wcnt_d  = wcnt_q;
        white_d = white_count;
        if (accept && frame_beat) begin
            wcnt_d = (sof ? '0 : wcnt_q) + CNT_W'(pix_white);
            if (done_d) begin
                white_d = wcnt_d;
                wcnt_d  = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wcnt_q      <= '0;
            white_count <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            white_count <= white_d;
        end
    end
`endif
endmodule

// File: doc/gray_threshold_stream.md
Name: gray_threshold_stream

Overview:
- AXI4-Stream stage directly downstream of convert_to_gray_top: consumes its 32-bit gray pixel stream, binarises each pixel against a programmable threshold and re-emits a 32-bit stream.
- Tracks frame geometry using TUSER (start of frame) and TLAST (end of line).
- Flags malformed frames and counts completed frames for software status.

Parameters:
- DATA_WIDTH, 32, stream data width; gray value is TDATA[7:0].
- DIM_W, 12, width of the column/row configuration and counters.
- FCNT_W, 16, width of frame_count.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- threshold  in  8  binarisation threshold; sampled at SOF acceptance.
- invert  in  1  swap black/white; sampled at SOF acceptance.
- cfg_cols  in  DIM_W  pixels per line; 0 disables geometry checks.
- cfg_rows  in  DIM_W  lines per frame; 0 disables geometry checks.
- clear_err  in  1  synchronous clear of sticky error flags.
- INPUT_STREAM_TVALID/TREADY  in/out  1  input handshake.
- INPUT_STREAM_TDATA  in  DATA_WIDTH  gray pixel.
- INPUT_STREAM_TKEEP, INPUT_STREAM_TSTRB  in  DATA_WIDTH/8  byte qualifiers.
- INPUT_STREAM_TUSER, INPUT_STREAM_TLAST, INPUT_STREAM_TID, INPUT_STREAM_TDEST  in  1 each  sideband (SOF, EOL, id, dest).
- OUTPUT_STREAM_TVALID/TREADY  out/in  1  output handshake.
- OUTPUT_STREAM_TDATA  out  DATA_WIDTH  binarised pixel.
- OUTPUT_STREAM_TKEEP, OUTPUT_STREAM_TSTRB  out  DATA_WIDTH/8  passed through.
- OUTPUT_STREAM_TUSER, OUTPUT_STREAM_TLAST, OUTPUT_STREAM_TID, OUTPUT_STREAM_TDEST  out  1 each  passed through.
- frame_done  out  1  one-cycle pulse on acceptance of the last beat of a complete frame.
- frame_count  out  FCNT_W  completed frames; wraps.
- err_eol_early, err_eol_late, err_sof_early  out  1 each  sticky error flags.

Behaviour:
- Reset values (aresetn low, asynchronous): all outputs 0, including OUTPUT_STREAM_TVALID=0 and INPUT_STREAM_TREADY=0; counters 0; state WAIT_SOF.
- INPUT_STREAM_TREADY goes to 1 on the first clock edge after reset deassertion.
- Datapath: registered output plus one skid entry; latency 1 cycle at full throughput.
- INPUT_STREAM_TREADY = skid entry empty. A beat is never dropped or duplicated.
- Output holds all signals stable while TVALID=1 and TREADY=0.
- Binarisation: pix = TDATA[7:0]; bit b = (pix >= thr_shadow) XOR inv_shadow.
- Output TDATA is b ? all-ones : all-zeros (every byte 0xFF or 0x00).
- Sideband signals are copied unchanged with their beat.
- Shadow capture: thr_shadow/inv_shadow load from threshold/invert when a beat with TUSER=1 is accepted. That beat already uses the new values. Mid-frame port changes are ignored.
- States:
  - WAIT_SOF: beats without TUSER pass through using the current shadow values; they are not counted and raise no errors. A TUSER beat moves to ACTIVE with col=0, row=0.
  - ACTIVE: each accepted beat advances col.
    - TLAST with col < cfg_cols-1: set err_eol_early; line ends.
    - col == cfg_cols-1 without TLAST: set err_eol_late; col saturates until TLAST.
    - On TLAST: col <= 0, row++.
    - TLAST with row == cfg_rows-1: frame_done pulse, frame_count++ (wraps at 2^FCNT_W), state <= WAIT_SOF.
  - TUSER in ACTIVE at col!=0 or row!=0: set err_sof_early; restart the frame at col=0, row=0 and recapture shadows. Do not return to WAIT_SOF.
- A single beat with both TUSER and TLAST is SOF and EOL of the same line.
- cfg_cols==0 or cfg_rows==0: no error flags are set and frame_done never pulses; pixels still pass through.
- Sticky flags: cleared by clear_err. If a new error occurs in the same cycle as clear_err, the set wins.
- Reset mid-frame discards the skid and output register contents; any in-flight beat is lost.

Optional Feature:
- Macro: GRAY_THRESH_STATS_EN.
- Defined: adds output white_count (2*DIM_W bits).
  - An internal counter increments per accepted ACTIVE beat with b=1.
  - On frame_done the count is copied to white_count and the counter is cleared.
  - The counter also clears on SOF restart.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Threshold: threshold=0x80, invert=0, cfg 4x2, pixels 0x7F,0x80,0xFF,0x00 -> TDATA 0x00000000, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000000; latency 1 cycle.
- Complete frame: 4x2 frame with correct TUSER/TLAST -> frame_done pulse on the 8th accepted beat, frame_count 0->1, no error flags. With GRAY_THRESH_STATS_EN, white_count equals the number of pixels >= threshold.
- Backpressure: random OUTPUT_STREAM_TREADY (50%) over 3 frames -> output sequence identical to input order, no loss, signals stable while stalled.
- Geometry errors:
  - TLAST on 3rd beat with cfg_cols=4 -> err_eol_early=1.
  - Next line with 5 beats and TLAST on the 5th -> err_eol_late=1.
  - clear_err -> both flags 0.
- SOF restart: TUSER at col=2, row=0, with threshold changed 0x80->0x10 -> err_sof_early=1; the TUSER beat is binarised with 0x10; counters restart.
- Reset mid-frame: aresetn low during beat 3 -> all outputs 0 immediately, state WAIT_SOF; the next frame completes normally with frame_count=1.
